// File: rtl/enet_tx_framer.sv
// Store-and-forward TX framer between the DDR controller and the MAC AXI-Stream port.
// Buffers payload words and emits fixed frames: two header words followed by PAYLOAD_WORDS payload beats.
module enet_tx_framer #(
  parameter int          PAYLOAD_WORDS = 128,
  parameter int          FIFO_DEPTH    = 256,
  parameter int          IFG_CYCLES    = 4,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_enet_enable,
  input  logic [47:0]                 i_dst_mac,
  input  logic [47:0]                 i_src_mac,
  input  logic [63:0]                 i_data,
  input  logic                        i_data_avail,
  output logic                        o_enet_ready,
  output logic [63:0]                 o_tx_tdata,
  output logic [7:0]                  o_tx_tkeep,
  output logic                        o_tx_tvalid,
  output logic                        o_tx_tlast,
  input  logic                        i_tx_tready,
  output logic                        o_tx_mac_count,
  output logic [31:0]                 o_frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(PAYLOAD_WORDS);
  localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [LW-1:0] FRAME_LEVEL = LW'(PAYLOAD_WORDS);
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(PAYLOAD_WORDS - 1);
  localparam logic [IW-1:0] LAST_IFG    = IW'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, IFG} state_t;

  state_t        state_q, state_d;
  logic [63:0]   fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q;
  logic [47:0]   dstMac_q, dstMac_d;
  logic [47:0]   srcMac_q, srcMac_d;
  logic [15:0]   frameSeq_q, frameSeq_d;
  logic [15:0]   seq_q, seq_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] ifg_q, ifg_d;
  logic [31:0]   frameCnt_q, frameCnt_d;
  logic          macCount_q, macCount_d;
  logic          wrEn, rdEn;

  assign wrEn = i_data_avail & ready_q;
  assign rdEn = (state_q == PAYLOAD) & i_tx_tready;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (wrEn) wrPtr_d = wrPtr_q + 1'b1;
    if (rdEn) rdPtr_d = rdPtr_q + 1'b1;
    case ({wrEn, rdEn})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Head word is read combinationally so each accepted beat is followed by the next word without a bubble.
  always_comb begin
    state_d    = state_q;
    dstMac_d   = dstMac_q;
    srcMac_d   = srcMac_q;
    frameSeq_d = frameSeq_q;
    seq_d      = seq_q;
    beat_d     = beat_q;
    ifg_d      = ifg_q;
    frameCnt_d = frameCnt_q;
    macCount_d = 1'b0;
    o_tx_tvalid = 1'b0;
    o_tx_tlast  = 1'b0;
    o_tx_tdata  = '0;
    case (state_q)
      IDLE: begin
        if (i_enet_enable && (level_q >= FRAME_LEVEL)) begin
          state_d    = HDR0;
          dstMac_d   = i_dst_mac;
          srcMac_d   = i_src_mac;
          frameSeq_d = seq_q;
        end
      end
      HDR0: begin
        o_tx_tvalid = 1'b1;
        o_tx_tdata  = {srcMac_q[39:32], srcMac_q[47:40], dstMac_q[7:0], dstMac_q[15:8],
                       dstMac_q[23:16], dstMac_q[31:24], dstMac_q[39:32], dstMac_q[47:40]};
        if (i_tx_tready) state_d = HDR1;
      end
      HDR1: begin
        o_tx_tvalid = 1'b1;
        o_tx_tdata  = {frameSeq_q[7:0], frameSeq_q[15:8], ETHERTYPE[7:0], ETHERTYPE[15:8],
                       srcMac_q[7:0], srcMac_q[15:8], srcMac_q[23:16], srcMac_q[31:24]};
        if (i_tx_tready) begin
          state_d = PAYLOAD;
          beat_d  = '0;
        end
      end
      PAYLOAD: begin
        o_tx_tvalid = 1'b1;
        o_tx_tdata  = fifoMem_q[rdPtr_q];
        o_tx_tlast  = (beat_q == LAST_BEAT);
        if (i_tx_tready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            macCount_d = 1'b1;
            seq_d      = seq_q + 16'd1;
            if (frameCnt_q != 32'hFFFF_FFFF) frameCnt_d = frameCnt_q + 32'd1;
            ifg_d   = '0;
            state_d = IFG;
          end
        end
      end
      IFG: begin
        if (ifg_q == LAST_IFG) state_d = IDLE;
        else ifg_d = ifg_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wrEn && !i_rst) fifoMem_q[wrPtr_q] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      dstMac_q   <= '0;
      srcMac_q   <= '0;
      frameSeq_q <= '0;
      seq_q      <= '0;
      beat_q     <= '0;
      ifg_q      <= '0;
      frameCnt_q <= '0;
      macCount_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      ready_q    <= (level_d < FULL_LEVEL);
      dstMac_q   <= dstMac_d;
      srcMac_q   <= srcMac_d;
      frameSeq_q <= frameSeq_d;
      seq_q      <= seq_d;
      beat_q     <= beat_d;
      ifg_q      <= ifg_d;
      frameCnt_q <= frameCnt_d;
      macCount_q <= macCount_d;
    end
  end

  assign o_enet_ready   = ready_q;
  assign o_tx_tkeep     = 8'hFF;
  assign o_tx_mac_count = macCount_q;
  assign o_frame_cnt    = frameCnt_q;
  assign o_fifo_level   = level_q;

endmodule

// File: tb/tb_enet_tx_framer.sv
// Self-checking bench for enet_tx_framer: payload words are queued as they are written and
// compared beat by beat against the AXI-Stream output, with headers rebuilt in wire byte order.
module tb_enet_tx_framer;

  localparam int PW  = 128;
  localparam int IFG = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enet_enable;
  logic [47:0] i_dst_mac;
  logic [47:0] i_src_mac;
  logic [63:0] i_data;
  logic        i_data_avail;
  logic        o_enet_ready;
  logic [63:0] o_tx_tdata;
  logic [7:0]  o_tx_tkeep;
  logic        o_tx_tvalid;
  logic        o_tx_tlast;
  logic        i_tx_tready;
  logic        o_tx_mac_count;
  logic [31:0] o_frame_cnt;
  logic [8:0]  o_fifo_level;

  int          compared = 0;
  int          mismatched = 0;
  logic [63:0] payloadQ [$];
  logic [47:0] dstMac;
  logic [47:0] srcMac;
  bit          randMode = 1'b0;

  int          beatIdx = 0;
  logic [15:0] expSeq = 16'd0;
  int          framesDone = 0;
  int          pulsesSeen = 0;
  bit          pulseExpected = 1'b0;
  bit          prevStall = 1'b0;
  logic [63:0] prevData = '0;
  logic        prevLast = 1'b0;
  int          cycleCnt = 0;
  int          lastPulseCycle = -1;
  logic [63:0] expData;
  logic        expLast;

  assign i_dst_mac = dstMac;
  assign i_src_mac = srcMac;

  always #5 i_clk = ~i_clk;

  enet_tx_framer dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_enet_enable  (i_enet_enable),
    .i_dst_mac      (i_dst_mac),
    .i_src_mac      (i_src_mac),
    .i_data         (i_data),
    .i_data_avail   (i_data_avail),
    .o_enet_ready   (o_enet_ready),
    .o_tx_tdata     (o_tx_tdata),
    .o_tx_tkeep     (o_tx_tkeep),
    .o_tx_tvalid    (o_tx_tvalid),
    .o_tx_tlast     (o_tx_tlast),
    .i_tx_tready    (i_tx_tready),
    .o_tx_mac_count (o_tx_mac_count),
    .o_frame_cnt    (o_frame_cnt),
    .o_fifo_level   (o_fifo_level)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Header bytes in wire order (dst, src, EtherType, seq; each MSB first), byte k at tdata[8k+7:8k].
  function automatic logic [63:0] hdrWord(input int w, input logic [47:0] d, input logic [47:0] s,
                                          input logic [15:0] seq);
    logic [7:0]  b [16];
    logic [63:0] r;
    for (int k = 0; k < 6; k++) begin
      b[k]     = d[47-8*k -: 8];
      b[6 + k] = s[47-8*k -: 8];
    end
    b[12] = 8'h88;
    b[13] = 8'hB5;
    b[14] = seq[15:8];
    b[15] = seq[7:0];
    for (int k = 0; k < 8; k++) r[8*k +: 8] = b[8*w + k];
    return r;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (randMode) i_tx_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [63:0] word);
    int budget;
    budget = 0;
    i_data = word;
    i_data_avail = 1'b1;
    while (!o_enet_ready && budget < 3000) begin
      tick();
      budget++;
    end
    checkOutput("write_ready", 64'(o_enet_ready), 64'd1);
    if (o_enet_ready) begin
      payloadQ.push_back(word);
      tick();
    end
    i_data_avail = 1'b0;
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    i_data_avail = 1'b0;
    payloadQ.delete();
    repeat (3) tick();
    checkOutput("rst_tvalid", 64'(o_tx_tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(o_tx_tlast), 64'd0);
    checkOutput("rst_mac_count", 64'(o_tx_mac_count), 64'd0);
    checkOutput("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    checkOutput("rst_level", 64'(o_fifo_level), 64'd0);
    checkOutput("rst_ready", 64'(o_enet_ready), 64'd0);
    i_rst = 1'b0;
    tick();
  endtask

  task automatic waitFrames(input int target);
    int budget;
    budget = 0;
    while (framesDone < target && budget < 5000) begin
      tick();
      budget++;
    end
    checkOutput("frame_wait", 64'(framesDone >= target), 64'd1);
  endtask

  task automatic waitPayloadBeat(input int n);
    int budget;
    budget = 0;
    while (beatIdx < n + 2 && budget < 2000) begin
      tick();
      budget++;
    end
    checkOutput("beat_wait", 64'(beatIdx >= n + 2), 64'd1);
  endtask

  // Output monitor: sampled on the falling edge, away from the edge where the DUT updates.
  always @(negedge i_clk) begin
    cycleCnt++;
    if (i_rst) begin
      beatIdx = 0;
      expSeq = 16'd0;
      pulseExpected = 1'b0;
      prevStall = 1'b0;
      lastPulseCycle = -1;
    end else begin
      checkOutput("mac_count", 64'(o_tx_mac_count), 64'(pulseExpected));
      pulseExpected = 1'b0;
      if (o_tx_mac_count) begin
        pulsesSeen++;
        if (lastPulseCycle >= 0)
          checkOutput("pulse_spacing", 64'((cycleCnt - lastPulseCycle) >= IFG + 3), 64'd1);
        lastPulseCycle = cycleCnt;
      end
      if (prevStall) begin
        checkOutput("stall_tvalid", 64'(o_tx_tvalid), 64'd1);
        checkOutput("stall_tdata", o_tx_tdata, prevData);
        checkOutput("stall_tlast", 64'(o_tx_tlast), 64'(prevLast));
      end else if (beatIdx > 0) begin
        checkOutput("tvalid_gap", 64'(o_tx_tvalid), 64'd1);
      end
      if (o_tx_tvalid) checkOutput("tkeep", 64'(o_tx_tkeep), 64'hFF);
      if (o_tx_tvalid && i_tx_tready) begin
        if (beatIdx < 2) begin
          expData = hdrWord(beatIdx, dstMac, srcMac, expSeq);
        end else begin
          checkOutput("queue_nonempty", 64'(payloadQ.size() > 0), 64'd1);
          expData = (payloadQ.size() > 0) ? payloadQ.pop_front() : 64'd0;
        end
        expLast = (beatIdx == PW + 1);
        checkOutput("tdata", o_tx_tdata, expData);
        checkOutput("tlast", 64'(o_tx_tlast), 64'(expLast));
        if (expLast) begin
          beatIdx = 0;
          expSeq = expSeq + 16'd1;
          framesDone++;
          pulseExpected = 1'b1;
        end else begin
          beatIdx++;
        end
      end
      prevStall = o_tx_tvalid && !i_tx_tready;
      prevData = o_tx_tdata;
      prevLast = o_tx_tlast;
    end
  end

  initial begin
    int base;
    bit started;
    i_rst = 1'b1;
    i_enet_enable = 1'b1;
    i_data = '0;
    i_data_avail = 1'b0;
    i_tx_tready = 1'b1;
    dstMac = 48'h0011_2233_4455;
    srcMac = 48'h6677_8899_AABB;
    doReset();

    $display("[TB] test 1: single frame of words 0..127");
    for (int i = 0; i < PW; i++) applyStimulus(64'(i));
    waitFrames(1);
    checkOutput("t1_frame_cnt", 64'(o_frame_cnt), 64'd1);
    tick();
    checkOutput("t1_level", 64'(o_fifo_level), 64'd0);
    checkOutput("t1_pulses", 64'(pulsesSeen), 64'd1);

    $display("[TB] test 2: 127 words hold, 128th starts frame");
    for (int i = 0; i < PW - 1; i++) applyStimulus(64'h1000 + 64'(i));
    repeat (10) begin
      tick();
      checkOutput("t2_idle_tvalid", 64'(o_tx_tvalid), 64'd0);
    end
    checkOutput("t2_level", 64'(o_fifo_level), 64'd127);
    applyStimulus(64'h1000 + 64'(PW - 1));
    started = 1'b0;
    for (int c = 0; c < 2 && !started; c++) begin
      tick();
      started = o_tx_tvalid;
    end
    checkOutput("t2_start", 64'(started), 64'd1);
    waitFrames(2);
    checkOutput("t2_frame_cnt", 64'(o_frame_cnt), 64'd2);

    $display("[TB] test 3: random tready over 4 frames");
    doReset();
    base = framesDone;
    randMode = 1'b1;
    for (int i = 0; i < 4 * PW; i++) applyStimulus({$urandom(), $urandom()});
    waitFrames(base + 4);
    randMode = 1'b0;
    i_tx_tready = 1'b1;
    base = pulsesSeen;
    tick();
    checkOutput("t3_frame_cnt", 64'(o_frame_cnt), 64'd4);
    checkOutput("t3_last_pulse", 64'(pulsesSeen - base), 64'd1);
    checkOutput("t3_level", 64'(o_fifo_level), 64'd0);

    $display("[TB] test 4: fill FIFO with tready low");
    doReset();
    base = framesDone;
    i_tx_tready = 1'b0;
    for (int i = 0; i < 255; i++) applyStimulus(64'h4000 + 64'(i));
    checkOutput("t4_ready_255", 64'(o_enet_ready), 64'd1);
    applyStimulus(64'h4000 + 64'd255);
    checkOutput("t4_ready_full", 64'(o_enet_ready), 64'd0);
    checkOutput("t4_level_full", 64'(o_fifo_level), 64'd256);
    checkOutput("t4_stalled_tvalid", 64'(o_tx_tvalid), 64'd1);
    i_tx_tready = 1'b1;
    for (int i = 256; i < 300; i++) applyStimulus(64'h4000 + 64'(i));
    waitFrames(base + 2);
    repeat (10) tick();
    checkOutput("t4_level_rem", 64'(o_fifo_level), 64'd44);
    checkOutput("t4_idle_tvalid", 64'(o_tx_tvalid), 64'd0);
    checkOutput("t4_frame_cnt", 64'(o_frame_cnt), 64'd2);

    $display("[TB] test 5: enable dropped mid-frame");
    i_enet_enable = 1'b0;
    dstMac = 48'hA1B2_C3D4_E5F6;
    srcMac = 48'h0102_0304_0506;
    base = framesDone;
    for (int i = 0; i < 212; i++) applyStimulus(64'h5000_0000 + 64'(i));
    checkOutput("t5_level_full", 64'(o_fifo_level), 64'd256);
    repeat (5) tick();
    checkOutput("t5_disabled_tvalid", 64'(o_tx_tvalid), 64'd0);
    i_enet_enable = 1'b1;
    waitPayloadBeat(50);
    i_enet_enable = 1'b0;
    waitFrames(base + 1);
    repeat (30) begin
      tick();
      checkOutput("t5_hold_tvalid", 64'(o_tx_tvalid), 64'd0);
    end
    checkOutput("t5_level_kept", 64'(o_fifo_level), 64'd128);
    i_enet_enable = 1'b1;
    waitFrames(base + 2);
    checkOutput("t5_level_empty", 64'(o_fifo_level), 64'd0);
    checkOutput("t5_frame_cnt", 64'(o_frame_cnt), 64'd4);

    $display("[TB] test 6: reset mid-frame");
    for (int i = 0; i < PW; i++) applyStimulus(64'h6000 + 64'(i));
    waitPayloadBeat(60);
    i_rst = 1'b1;
    payloadQ.delete();
    tick();
    checkOutput("t6_tvalid", 64'(o_tx_tvalid), 64'd0);
    checkOutput("t6_level", 64'(o_fifo_level), 64'd0);
    checkOutput("t6_frame_cnt", 64'(o_frame_cnt), 64'd0);
    tick();
    i_rst = 1'b0;
    tick();
    base = framesDone;
    for (int i = 0; i < PW; i++) applyStimulus(64'h7000 + 64'(i));
    waitFrames(base + 1);
    checkOutput("t6_frame_cnt_after", 64'(o_frame_cnt), 64'd1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
